// File: rtl/mem_req_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_req_queue_if
// Brief    : Host request/response handshakes and SDRAM controller command
//            port of the memory request queue, bundled with modports.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_req_queue_if;
    // Host request channel
    logic        req_vld;
    logic        req_rdy;
    logic        req_rdnwr;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    // Host read-response channel
    logic        rsp_vld;
    logic        rsp_rdy;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    // SDRAM controller command port
    logic        cmd_n;
    logic        RDnWR;
    logic [15:0] Addr_in;
    logic [31:0] Data_in;
    logic        Data_in_vld;
    logic        ctrl_done;
    logic [31:0] Data_out;

    modport slave (
        input  req_vld, req_rdnwr, req_addr, req_wdata, rsp_rdy, ctrl_done, Data_out,
        output req_rdy, rsp_vld, rsp_rdata, rsp_err,
        output cmd_n, RDnWR, Addr_in, Data_in, Data_in_vld
    );

    modport master (
        output req_vld, req_rdnwr, req_addr, req_wdata, rsp_rdy, ctrl_done, Data_out,
        input  req_rdy, rsp_vld, rsp_rdata, rsp_err,
        input  cmd_n, RDnWR, Addr_in, Data_in, Data_in_vld
    );
endinterface
`default_nettype wire

// File: rtl/mem_req_queue.sv
`default_nettype none
// ============================================================================
// Module   : mem_req_queue
// Brief    : DEPTH-entry in-order request FIFO in front of the SDRAM
//            controller; one request outstanding, read data returned to host.
//            Optional WAIT timeout enabled by defining REQ_QUEUE_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mem_req_queue #(
    parameter int DEPTH   = 8
`ifdef REQ_QUEUE_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 64
`endif
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mem_req_queue_if.slave         bus,
    output logic [$clog2(DEPTH):0] q_count,
    output logic                   timeout_err
);

    localparam int              c_AW   = $clog2(DEPTH);
    localparam int              c_EW   = 49;
    localparam logic [c_AW:0]   c_FULL = DEPTH[c_AW:0];

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } t_state;

    t_state            r_state;
    t_state            w_next;

    logic [c_EW-1:0]   r_mem [DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_AW:0]     r_count;

    logic              r_cmd_n;
    logic              r_rdnwr;
    logic [15:0]       r_addr;
    logic [31:0]       r_wdata;
    logic              r_wdata_vld;
    logic              r_rsp_vld;
    logic [31:0]       r_rsp_rdata;

    logic              w_req_rdy;
    logic              w_push;
    logic              w_pop;
    logic              w_done;
    logic              w_timeout;
    logic              w_finish;
    logic [c_EW-1:0]   w_head;

    assign w_req_rdy = (r_count < c_FULL) && rst_n;
    assign w_push    = bus.req_vld && w_req_rdy;
    assign w_pop     = (r_state == S_IDLE) && (r_count != '0);
    assign w_head    = r_mem[r_rd_ptr];
    assign w_done    = (r_state == S_WAIT) && bus.ctrl_done;
    assign w_finish  = w_done || w_timeout;

    // ---------------- FIFO storage and occupancy ----------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.req_rdnwr, bus.req_addr, bus.req_wdata};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (r_count != '0) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (w_finish) w_next = r_rdnwr ? S_RESP : S_IDLE;
            S_RESP:  if (bus.rsp_rdy) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Command strobe is registered so it is low exactly during ISSUE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cmd_n     <= 1'b1;
            r_rdnwr     <= 1'b1;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wdata_vld <= 1'b0;
        end else begin
            r_cmd_n <= !w_pop;
            if (w_pop) begin
                {r_rdnwr, r_addr, r_wdata} <= w_head;
                r_wdata_vld                <= ~w_head[c_EW-1];
            end else if (w_finish && !r_rdnwr) begin
                r_wdata_vld <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rsp_vld   <= 1'b0;
            r_rsp_rdata <= '0;
        end else if (w_finish && r_rdnwr) begin
            r_rsp_vld   <= 1'b1;
            r_rsp_rdata <= w_timeout ? 32'd0 : bus.Data_out;
        end else if ((r_state == S_RESP) && bus.rsp_rdy) begin
            r_rsp_vld   <= 1'b0;
        end
    end

`ifdef REQ_QUEUE_TIMEOUT_EN
    localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT - 1);

    logic [7:0] r_wait_cnt;
    logic       r_rsp_err;
    logic       r_timeout_err;

    // A completion in the final WAIT cycle takes priority over the timeout.
    assign w_timeout = (r_state == S_WAIT) && !bus.ctrl_done && (r_wait_cnt == c_TO_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wait_cnt    <= '0;
            r_rsp_err     <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == S_ISSUE)     r_wait_cnt <= '0;
            else if (r_state == S_WAIT) r_wait_cnt <= r_wait_cnt + 8'd1;
            if (w_timeout) r_timeout_err <= 1'b1;
            if (w_timeout && r_rdnwr)                      r_rsp_err <= 1'b1;
            else if ((r_state == S_RESP) && bus.rsp_rdy)   r_rsp_err <= 1'b0;
        end
    end

    assign bus.rsp_err = r_rsp_err;
    assign timeout_err = r_timeout_err;
`else
    assign w_timeout   = 1'b0;
    assign bus.rsp_err = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign bus.req_rdy     = w_req_rdy;
    assign bus.cmd_n       = r_cmd_n;
    assign bus.RDnWR       = r_rdnwr;
    assign bus.Addr_in     = r_addr;
    assign bus.Data_in     = r_wdata;
    assign bus.Data_in_vld = r_wdata_vld;
    assign bus.rsp_vld     = r_rsp_vld;
    assign bus.rsp_rdata   = r_rsp_rdata;
    assign q_count         = r_count;

endmodule
`default_nettype wire

// File: tb/tb_mem_req_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_req_queue
// Brief    : Self-checking bench for mem_req_queue: directed scenarios plus
//            randomized traffic against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_req_queue;
    localparam int DEPTH = 8;
`ifdef REQ_QUEUE_TIMEOUT_EN
    localparam int TIMEOUT = 16;
`endif

    logic                   clk   = 1'b0;
    logic                   rst_n = 1'b0;
    logic [$clog2(DEPTH):0] q_count;
    logic                   timeout_err;
    int                     checks   = 0;
    int                     failures = 0;

    mem_req_queue_if bus();

    mem_req_queue #(
        .DEPTH(DEPTH)
`ifdef REQ_QUEUE_TIMEOUT_EN
        , .TIMEOUT(TIMEOUT)
`endif
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .q_count     (q_count),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (transaction level) ----------------
    logic [48:0] mq[$];
    logic [15:0] issued[$];
    bit          m_busy = 1'b0;
    int          m_wait_cycles = 0;
    logic        e_cmd_n, e_rdnwr, e_wvld, e_rsp_vld, e_rsp_err, e_terr;
    logic [15:0] e_addr;
    logic [31:0] e_wdata, e_rdata;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void finish_req(input bit normal, input logic [31:0] rdata);
        if (e_rdnwr) begin
            e_rsp_vld = 1'b1;
            e_rdata   = normal ? rdata : 32'd0;
            e_rsp_err = !normal;
        end else begin
            e_wvld = 1'b0;
            m_busy = 1'b0;
        end
    endfunction

    function automatic void model_step();
        bit          push, pop;
        logic [48:0] ent;
        if (!rst_n) begin
            mq.delete();
            m_busy = 1'b0;
            e_cmd_n = 1'b1; e_rdnwr = 1'b1; e_addr = '0; e_wdata = '0; e_wvld = 1'b0;
            e_rsp_vld = 1'b0; e_rdata = '0; e_rsp_err = 1'b0; e_terr = 1'b0;
            return;
        end
        push = bus.req_vld && (mq.size() < DEPTH);
        pop  = !m_busy && (mq.size() > 0);
        if (e_rsp_vld) begin
            if (bus.rsp_rdy) begin
                e_rsp_vld = 1'b0; e_rsp_err = 1'b0; m_busy = 1'b0;
            end
        end else if (!e_cmd_n) begin
            e_cmd_n = 1'b1;
            m_wait_cycles = 0;
        end else if (m_busy) begin
            m_wait_cycles++;
            if (bus.ctrl_done) finish_req(1'b1, bus.Data_out);
`ifdef REQ_QUEUE_TIMEOUT_EN
            else if (m_wait_cycles == TIMEOUT) begin
                e_terr = 1'b1;
                finish_req(1'b0, 32'd0);
            end
`endif
        end
        if (pop) begin
            ent = mq.pop_front();
            {e_rdnwr, e_addr, e_wdata} = ent;
            e_wvld  = ~ent[48];
            e_cmd_n = 1'b0;
            m_busy  = 1'b1;
        end
        if (push) mq.push_back({bus.req_rdnwr, bus.req_addr, bus.req_wdata});
    endfunction

    always @(posedge clk) begin
        model_step();
        #1;
        chk("req_rdy", bus.req_rdy, (rst_n && (mq.size() < DEPTH)));
        chk("cmd_n", bus.cmd_n, e_cmd_n);
        chk("Data_in_vld", bus.Data_in_vld, e_wvld);
        chk("rsp_vld", bus.rsp_vld, e_rsp_vld);
        chk("rsp_err", bus.rsp_err, e_rsp_err);
        chk("q_count", q_count, mq.size());
        chk("timeout_err", timeout_err, e_terr);
        if (m_busy) begin
            chk("RDnWR", bus.RDnWR, e_rdnwr);
            chk("Addr_in", bus.Addr_in, e_addr);
            chk("Data_in", bus.Data_in, e_wdata);
        end
        if (e_rsp_vld) chk("rsp_rdata", bus.rsp_rdata, e_rdata);
        if (bus.cmd_n === 1'b0) issued.push_back(bus.Addr_in);
    end

    // ---------------- stimulus ----------------
    bit rand_req  = 1'b0;
    bit auto_done = 1'b0;
    bit pend      = 1'b0;
    int dly       = 0;

    task automatic tick();
        @(negedge clk);
        if (auto_done) begin
            bus.ctrl_done = 1'b0;
            if (!rst_n) pend = 1'b0;
            else if (bus.cmd_n == 1'b0) begin
                pend = 1'b1;
                dly  = int'($urandom_range(0, 6));
            end else if (pend) begin
                if (dly == 0) begin
                    bus.ctrl_done = 1'b1; bus.Data_out = $urandom(); pend = 1'b0;
                end else dly--;
            end else if (rand_req && ($urandom_range(0, 7) == 0)) begin
                bus.ctrl_done = 1'b1; bus.Data_out = $urandom();
            end
        end
        if (rand_req) begin
            rst_n         = ($urandom_range(0, 299) != 0);
            bus.req_vld   = ($urandom_range(0, 3) != 0);
            bus.req_rdnwr = 1'($urandom_range(0, 1));
            bus.req_addr  = 16'($urandom());
            bus.req_wdata = $urandom();
            bus.rsp_rdy   = ($urandom_range(0, 2) != 0);
        end
    endtask

    task automatic push_req(input logic rd, input logic [15:0] a, input logic [31:0] d);
        bus.req_vld = 1'b1; bus.req_rdnwr = rd; bus.req_addr = a; bus.req_wdata = d;
        tick();
        bus.req_vld = 1'b0;
    endtask

    initial begin
        int n;
        int seen;
        bus.req_vld = 1'b0; bus.req_rdnwr = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.rsp_rdy = 1'b0; bus.ctrl_done = 1'b0; bus.Data_out = '0;
        repeat (3) tick();
        chk("rst_req_rdy", bus.req_rdy, 1'b0);
        chk("rst_cmd_n", bus.cmd_n, 1'b1);
        chk("rst_RDnWR", bus.RDnWR, 1'b1);
        chk("rst_Addr_in", bus.Addr_in, 16'h0);
        chk("rst_Data_in_vld", bus.Data_in_vld, 1'b0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        chk("rst_q_count", q_count, 0);
        rst_n = 1'b1;
        tick();

        // Write: strobe one cycle after acceptance, no response afterwards.
        push_req(1'b0, 16'h1234, 32'hCAFE_F00D);
        chk("wr_q_count_push", q_count, 1);
        tick();
        chk("wr_cmd_n", bus.cmd_n, 1'b0);
        chk("wr_RDnWR", bus.RDnWR, 1'b0);
        chk("wr_Addr_in", bus.Addr_in, 16'h1234);
        chk("wr_Data_in", bus.Data_in, 32'hCAFE_F00D);
        chk("wr_Data_in_vld", bus.Data_in_vld, 1'b1);
        repeat (3) tick();
        chk("wr_cmd_n_wait", bus.cmd_n, 1'b1);
        bus.ctrl_done = 1'b1;
        tick();
        bus.ctrl_done = 1'b0;
        chk("wr_vld_cleared", bus.Data_in_vld, 1'b0);
        chk("wr_no_rsp", bus.rsp_vld, 1'b0);
        chk("wr_q_count_end", q_count, 0);

        // Read: response held while rsp_rdy low, drops after handshake.
        push_req(1'b1, 16'hF00F, 32'h0);
        tick();
        chk("rd_Addr_in", bus.Addr_in, 16'hF00F);
        tick();
        bus.ctrl_done = 1'b1; bus.Data_out = 32'hA5A5_5A5A;
        tick();
        bus.ctrl_done = 1'b0; bus.Data_out = 32'h0;
        chk("rd_rsp_vld", bus.rsp_vld, 1'b1);
        chk("rd_rsp_rdata", bus.rsp_rdata, 32'hA5A5_5A5A);
        chk("rd_rsp_err", bus.rsp_err, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rd_rsp_hold", bus.rsp_vld, 1'b1);
        end
        bus.rsp_rdy = 1'b1;
        tick();
        bus.rsp_rdy = 1'b0;
        chk("rd_rsp_drop", bus.rsp_vld, 1'b0);

        // Nine writes with completion withheld: queue fills, then drains in order.
        issued.delete();
        for (int i = 0; i < 9; i++) begin
            bus.req_vld = 1'b1; bus.req_rdnwr = 1'b0;
            bus.req_addr = 16'h0100 + 16'(i); bus.req_wdata = 32'(i);
            tick();
        end
        chk("full_q_count", q_count, 8);
        chk("full_req_rdy", bus.req_rdy, 1'b0);
        bus.req_addr = 16'h01FF;
        tick();
        bus.req_vld = 1'b0;
        chk("full_no_push", q_count, 8);
        bus.ctrl_done = 1'b1;
        tick();
        auto_done = 1'b1;
        n = 0;
        while (issued.size() < 9 && n < 300) begin tick(); n++; end
        repeat (20) tick();
        chk("order_count", issued.size(), 9);
        for (int i = 0; i < 9 && i < issued.size(); i++)
            chk("order_addr", issued[i], 16'h0100 + 16'(i));
        auto_done = 1'b0;
        bus.ctrl_done = 1'b0;

        // Reset while WAITing with three entries queued.
        for (int i = 0; i < 4; i++) push_req(1'b0, 16'h0200 + 16'(i), 32'h0);
        chk("pre_rst_q_count", q_count, 3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("post_rst_q_count", q_count, 0);
        chk("post_rst_cmd_n", bus.cmd_n, 1'b1);
        chk("post_rst_rsp_vld", bus.rsp_vld, 1'b0);
        issued.delete();
        repeat (10) tick();
        chk("post_rst_no_strobe", issued.size(), 0);

        // Read with no completion at all.
        push_req(1'b1, 16'h0ABC, 32'h0);
`ifdef REQ_QUEUE_TIMEOUT_EN
        n = 0;
        while (!bus.rsp_vld && n < 60) begin tick(); n++; end
        chk("to_latency", n, TIMEOUT + 2);
        chk("to_rsp_vld", bus.rsp_vld, 1'b1);
        chk("to_rsp_err", bus.rsp_err, 1'b1);
        chk("to_rsp_rdata", bus.rsp_rdata, 32'h0);
        chk("to_flag", timeout_err, 1'b1);
        bus.rsp_rdy = 1'b1;
        tick();
        bus.rsp_rdy = 1'b0;
        chk("to_rsp_drop", bus.rsp_vld, 1'b0);
        chk("to_err_clear", bus.rsp_err, 1'b0);
        chk("to_flag_sticky", timeout_err, 1'b1);
`else
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.rsp_vld) seen++;
        end
        chk("no_timeout_rsp", seen, 0);
`endif
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_timeout_err", timeout_err, 1'b0);

        // Randomized traffic.
        auto_done = 1'b1;
        rand_req  = 1'b1;
        repeat (3000) tick();
        rand_req    = 1'b0;
        rst_n       = 1'b1;
        bus.req_vld = 1'b0;
        bus.rsp_rdy = 1'b1;
        repeat (150) tick();
        chk("drain_q_count", q_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
